// File: rtl/icache_sa.sv
// Set-associative instruction cache with flop-based tag/valid/data arrays,
// single-cycle hits, line-refill bursts, fence.i style flush and hit/miss counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | accept fetches, look up all ways, apply pending flush
// MISS_REQ | hold refill request on the memory port until accepted
// REFILL   | write incoming beats into the victim way
// RESP     | present the captured word for one cycle
module icache_sa #(
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic [31:0] cpu_pc,
  output logic        cpu_resp_valid,
  output logic [31:0] cpu_inst,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int TAG_W  = 32 - OFF_W - IDX_W;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MISS_REQ = 2'd1;
  localparam logic [1:0] S_REFILL   = 2'd2;
  localparam logic [1:0] S_RESP     = 2'd3;

  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

  logic [1:0]        state;
  logic [SETS-1:0]   valid [WAYS];
  logic [SETS-1:0]   lru;
  logic [TAG_W-1:0]  tag_arr [WAYS][SETS];
  logic [31:0]       data_arr [WAYS][SETS][LINE_WORDS];
  logic              flush_pend;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] word_q;
  logic              victim_q;
  logic [WORD_W-1:0] beat;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_word;
  logic              accept;
  logic              hit;
  logic              hit_way;
  logic [31:0]       hit_data;
  logic              victim;
  logic              refill_beat;
  logic              last_beat;
  logic [1:0]        unused_pc;

  assign req_tag   = cpu_pc[31 -: TAG_W];
  assign req_idx   = cpu_pc[OFF_W +: IDX_W];
  assign req_word  = cpu_pc[2 +: WORD_W];
  assign unused_pc = cpu_pc[1:0];

  assign cpu_req_ready = (state == S_IDLE) && !flush_pend;
  assign accept        = cpu_req_valid && cpu_req_ready;
  assign refill_beat   = (state == S_REFILL) && mem_resp_valid;
  assign last_beat     = refill_beat && (beat == LAST_BEAT);

  always_comb begin
    hit      = 1'b0;
    hit_way  = 1'b0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[w][req_idx] && (tag_arr[w][req_idx] == req_tag)) begin
        hit      = 1'b1;
        hit_way  = 1'(w);
        hit_data = data_arr[w][req_idx][req_word];
      end
    end
  end

  // Lowest-numbered invalid way wins; otherwise the set's LRU bit names the victim.
  always_comb begin
    victim = (WAYS == 1) ? 1'b0 : lru[req_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w][req_idx]) victim = 1'(w);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      for (int w = 0; w < WAYS; w++) valid[w] <= '0;
      lru            <= '0;
      flush_pend     <= 1'b0;
      tag_q          <= '0;
      idx_q          <= '0;
      word_q         <= '0;
      victim_q       <= 1'b0;
      beat           <= '0;
      cpu_resp_valid <= 1'b0;
      cpu_inst       <= '0;
      mem_req_valid  <= 1'b0;
      mem_req_addr   <= '0;
      hit_count      <= '0;
      miss_count     <= '0;
    end else begin
      cpu_resp_valid <= 1'b0;
      if (flush && (state != S_IDLE)) flush_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (flush_pend) begin
            for (int w = 0; w < WAYS; w++) valid[w] <= '0;
            flush_pend <= 1'b0;
          end else if (accept) begin
            if (flush) flush_pend <= 1'b1;
            if (hit) begin
              cpu_resp_valid <= 1'b1;
              cpu_inst       <= hit_data;
              hit_count      <= hit_count + 32'd1;
              if (WAYS > 1) lru[req_idx] <= ~hit_way;
            end else begin
              miss_count    <= miss_count + 32'd1;
              tag_q         <= req_tag;
              idx_q         <= req_idx;
              word_q        <= req_word;
              victim_q      <= victim;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {cpu_pc[31:OFF_W], {OFF_W{1'b0}}};
              state         <= S_MISS_REQ;
            end
          end else if (flush) begin
            for (int w = 0; w < WAYS; w++) valid[w] <= '0;
          end
        end
        S_MISS_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            beat          <= '0;
            state         <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (refill_beat) begin
            if (beat == word_q) cpu_inst <= mem_resp_data;
            beat <= beat + 1'b1;
            if (last_beat) begin
              valid[victim_q][idx_q] <= 1'b1;
              if (WAYS > 1) lru[idx_q] <= ~victim_q;
              cpu_resp_valid <= 1'b1;
              beat           <= '0;
              state          <= S_RESP;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage arrays carry no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (refill_beat) begin
      data_arr[victim_q][idx_q][beat] <= mem_resp_data;
      if (last_beat) tag_arr[victim_q][idx_q] <= tag_q;
    end
  end

endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised set-associative instruction cache between the fetch stage and the instruction memory bus. Fetch requests are looked up against flop-based tag/valid/data arrays; hits return in one cycle and misses run a line-refill burst on the memory port. The block also supports whole-cache invalidation (fence.i) and provides hit/miss counters. It replaces the simulation-only lookup with synthesisable RTL.

## Interface
- SETS, 64, number of sets; power of two, ≥2
- WAYS, 2, associativity; 1 or 2
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cpu_req_valid  in  1  fetch request
- cpu_req_ready  out  1  cache can accept a request this cycle
- cpu_pc  in  32  fetch address; bits [1:0] ignored
- cpu_resp_valid  out  1  one-cycle pulse: cpu_inst is valid
- cpu_inst  out  32  fetched instruction
- flush  in  1  invalidate all lines (single-cycle pulse)
- mem_req_valid  out  1  line refill request
- mem_req_ready  in  1  memory accepts refill request
- mem_req_addr  out  32  line-aligned refill address
- mem_resp_valid  in  1  refill data beat
- mem_resp_data  in  32  beat data, word 0 first
- hit_count  out  32  accepted requests that hit, wraps
- miss_count  out  32  accepted requests that missed, wraps

## Operation
- Address split: [1:0] byte, next log2(LINE_WORDS) word, next log2(SETS) index, remainder tag.
- States: IDLE, MISS_REQ, REFILL, RESP.
- IDLE: cpu_req_ready = 1 unless a flush is pending. On accept (valid & ready), all ways of the indexed set are compared combinationally.
  - Hit: cpu_inst/cpu_resp_valid registered next cycle; hit_count++; LRU bit of the set points to the non-hit way; stay IDLE.
  - Miss: miss_count++; latch pc; go to MISS_REQ.
- MISS_REQ: mem_req_valid = 1, mem_req_addr = {pc[31:offset], zeros}; held stable until mem_req_ready; then go to REFILL.
- REFILL: each mem_resp_valid writes the next word (beat counter 0..LINE_WORDS-1) into the victim way. The beat matching the requested word is captured for the response. On the last beat, write the tag and set valid, update LRU to point away from the victim, and go to RESP.
- Victim: WAYS=1 uses way 0. WAYS=2 uses the first invalid way (way 0 preferred), else the way named by the set's LRU bit.
- RESP: cpu_resp_valid = 1 with the captured word for one cycle; return to IDLE. cpu_req_ready stays 0 in RESP.
- No backpressure on the response; the fetch stage must consume the pulse.
- flush in IDLE, with no request accepted that cycle: clear all valid bits next edge. LRU bits are unchanged.
- flush in any other state, or coincident with an accepted request: latch as pending.
  - The in-flight refill still completes and still delivers its response. Its line is written valid.
  - The pending clear applies on the first IDLE cycle. cpu_req_ready = 0 during that cycle.
- Reset: all valid bits 0, LRU bits 0, state IDLE, beat counter 0, cpu_resp_valid 0, cpu_inst 0, mem_req_valid 0, mem_req_addr 0, counters 0, flush pending 0.
- Reset asserted mid-refill abandons the burst. The bench/memory model must also drop the outstanding burst.
- Data arrays are not reset.

## Timing
- Hit latency: request accepted at edge N, cpu_resp_valid high in cycle N+1. Back-to-back hits sustain 1 per cycle.
- Miss: mem_req_valid high from cycle N+1 until handshake.
- Response: last beat at cycle M gives cpu_resp_valid in M+1. cpu_req_ready is high again in M+2.
- Minimum miss penalty with zero-wait memory: LINE_WORDS + 3 cycles.
- mem_resp_valid outside REFILL is ignored.
- Counters increment on the accept edge and wrap 0xFFFFFFFF→0.

## Test plan
- Cold miss, SETS=64, WAYS=2, LINE_WORDS=4: fetch 0x0000_1008.
  - Required: one refill request at 0x0000_1000.
  - Beats 0xA0..0xA3 return cpu_inst=0xA2.
  - miss_count=1.
- Hit streaming after the cold miss: fetch 0x1000, 0x1004, 0x100C on consecutive cycles.
  - Required: 0xA0, 0xA1, 0xA3 on three consecutive cycles.
  - hit_count=3, no mem_req_valid.
- LRU eviction: fill 0x1000 and 0x2000 (same set), hit 0x1000, then miss 0x3000.
  - Required: 0x2000's way is replaced.
  - A following fetch of 0x1000 hits; 0x2000 misses.
- Flush: after the fills above, pulse flush in IDLE, then fetch 0x1000.
  - Required: a miss with a new refill request.
  - Flush asserted during REFILL: the response is still delivered, cpu_req_ready=0 for one IDLE cycle, and the next fetch of the refilled line misses.
- Memory backpressure: mem_req_ready low for 5 cycles.
  - Required: mem_req_valid and mem_req_addr are held stable, and cpu_req_ready stays 0 throughout.
- Reset mid-refill after 2 beats.
  - Required: all outputs return to their reset values; a subsequent fetch of the same line misses and refills fully.
